arp_reply_tx: RTL and testbench
===============================

Name: arp_reply_tx

Overview:
Downstream neighbour of the ARP receive parser. It consumes a validated ARP request (requester MAC/IP plus a one-cycle valid strobe) and emits a complete Ethernet/ARP reply frame as a byte stream with valid/ready/last handshake. The stream feeds the MAC TX stage, which adds preamble/SFD and FCS. The block holds one pending request so it never loses the strobe while a frame is in flight.

Parameters:
PAD_EN, 1, 1 = pad frame to 60 bytes (FCS excluded) with 0x00; 0 = end frame at byte 41.
IFG_CYCLES, 0, minimum idle cycles forced between the tlast beat and the next first beat (0..255).

Ports:
mac_gmii_tx_clk  in  1  block clock; all inputs synchronous to it (CDC handled upstream).
mac_gmii_tx_rst  in  1  synchronous reset, active-high.
rq_mac_s_addr  in  48  requester MAC (sender HW addr of received request).
rq_ip_s_addr  in  32  requester IP.
rq_valid  in  1  one-cycle strobe: request validated.
local_mac_addr  in  48  own MAC.
local_ip_addr  in  32  own IP.
m_tdata  out  8  frame byte.
m_tvalid  out  1  byte valid.
m_tready  in  1  downstream accepts byte.
m_tlast  out  1  last byte of frame.
busy  out  1  frame in flight or IFG running.
rq_drop  out  1  one-cycle pulse: pending request overwritten.

Behaviour:
- Reset: m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, rq_drop=0, pending empty, state IDLE, byte counter 0.
- Pending slot: rq_valid captures rq_mac_s_addr, rq_ip_s_addr, local_mac_addr, local_ip_addr into pending. If the slot is already full and not consumed that cycle, overwrite (latest wins) and pulse rq_drop next cycle.
- FSM: IDLE -> SEND when pending full; the same edge moves pending into the active frame registers, clears pending (a simultaneous rq_valid refills it, no drop), sets byte counter 0, m_tvalid=1. First byte is visible one cycle after rq_valid when idle.
- SEND: byte advances only on m_tvalid && m_tready; m_tdata/m_tvalid/m_tlast stable while m_tready=0. After the last byte is accepted -> GAP if IFG_CYCLES>0, else IDLE (or directly SEND if pending full, back-to-back).
- GAP: m_tvalid=0; counts IFG_CYCLES cycles, then IDLE.
- busy=1 in SEND and GAP.
- Byte map (index: value): 0-5 requester MAC; 6-11 local MAC; 12-13 08 06; 14-15 00 01; 16-17 08 00; 18 06; 19 04; 20-21 00 02; 22-27 local MAC; 28-31 local IP; 32-37 requester MAC; 38-41 requester IP; 42-59 00 when PAD_EN=1. Multi-byte fields MSB first.
- m_tlast=1 exactly on index 59 (PAD_EN=1) or 41 (PAD_EN=0).
- Byte counter 6 bits, never wraps; return to 0 at frame end.
- Reset mid-frame: output drops immediately next edge to reset values; partial frame is abandoned (downstream must tolerate truncation via reset); pending cleared.
- local_* changes during a frame do not affect the frame in flight.

Test Plan:
- Single request: rq_mac_s_addr=00:11:22:33:44:55, rq_ip_s_addr=C0A80102, local=02:00:00:00:00:01/C0A8010A, m_tready=1 -> 60 bytes on consecutive cycles starting the cycle after rq_valid, bytes 0-5=00 11 22 33 44 55, 20-21=00 02, 28-31=C0 A8 01 0A, 38-41=C0 A8 01 02, tlast on byte 59.
- Backpressure: m_tready toggled 1,0,0,1 pattern -> identical 60-byte sequence, data/last stable during stalls, no duplicated or skipped bytes.
- Request while busy: second rq_valid (IP C0A80103) at byte 10 -> second frame starts on the cycle after first tlast (IFG_CYCLES=0) with bytes 38-41=C0 A8 01 03, rq_drop never asserted.
- Overwrite: third rq_valid (IP C0A80104) during same frame after second -> rq_drop pulses once, second frame carries C0A80104, only two frames total.
- IFG_CYCLES=12, two queued requests -> exactly 12 cycles with m_tvalid=0 between frames, busy=1 throughout.
- PAD_EN=0 -> 42-byte frame, tlast on byte 41; reset asserted at byte 20 -> m_tvalid=0 next cycle, no further bytes, next request produces a complete frame from byte 0.

Source files
------------

// File: rtl/arp_reply_tx.sv
// ARP reply frame generator: turns a validated ARP request into an
// Ethernet/ARP reply byte stream for the MAC TX stage (no preamble/FCS).
module arp_reply_tx #(
    parameter int PAD_EN     = 1,
    parameter int IFG_CYCLES = 0
) (
    input  logic        mac_gmii_tx_clk,
    input  logic        mac_gmii_tx_rst,
    input  logic [47:0] rq_mac_s_addr,
    input  logic [31:0] rq_ip_s_addr,
    input  logic        rq_valid,
    input  logic [47:0] local_mac_addr,
    input  logic [31:0] local_ip_addr,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic        rq_drop
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    localparam logic [5:0] LAST_IDX = (PAD_EN != 0) ? 6'd59 : 6'd41;
    localparam bit         HAS_GAP  = (IFG_CYCLES > 0);
    localparam logic [7:0] GAP_LAST = HAS_GAP ? 8'(IFG_CYCLES - 1) : 8'd0;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  cnt_q;
    logic [5:0]  cnt_d;
    logic [7:0]  gap_q;
    logic [7:0]  gap_d;
    logic        load;
    logic        avail;
    logic        accept;

    logic        pend_full;
    logic [47:0] pend_rq_mac;
    logic [31:0] pend_rq_ip;
    logic [47:0] pend_loc_mac;
    logic [31:0] pend_loc_ip;

    logic [47:0] src_rq_mac;
    logic [31:0] src_rq_ip;
    logic [47:0] src_loc_mac;
    logic [31:0] src_loc_ip;

    logic [47:0] act_rq_mac;
    logic [31:0] act_rq_ip;
    logic [47:0] act_loc_mac;
    logic [31:0] act_loc_ip;

    logic        drop_q;
    logic [335:0] frame;
    logic [335:0] frame_sh;

    assign m_tvalid = (state_q == SEND);
    assign m_tlast  = m_tvalid && (cnt_q == LAST_IDX);
    assign busy     = (state_q != IDLE);
    assign rq_drop  = drop_q;
    assign accept   = m_tvalid && m_tready;
    assign avail    = pend_full || rq_valid;

    // An empty slot lets a fresh strobe bypass straight into the frame.
    always_comb begin
        src_rq_mac  = rq_mac_s_addr;
        src_rq_ip   = rq_ip_s_addr;
        src_loc_mac = local_mac_addr;
        src_loc_ip  = local_ip_addr;
        if (pend_full) begin
            src_rq_mac  = pend_rq_mac;
            src_rq_ip   = pend_rq_ip;
            src_loc_mac = pend_loc_mac;
            src_loc_ip  = pend_loc_ip;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (avail) begin
                    state_d = SEND;
                    cnt_d   = 6'd0;
                    load    = 1'b1;
                end
            end
            SEND: begin
                if (accept) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = 6'd0;
                        gap_d = 8'd0;
                        if (HAS_GAP) begin
                            state_d = GAP;
                        end else if (avail) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = 8'd0;
                    if (avail) begin
                        state_d = SEND;
                        cnt_d   = 6'd0;
                        load    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge mac_gmii_tx_clk) begin
        if (mac_gmii_tx_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 6'd0;
            gap_q        <= 8'd0;
            drop_q       <= 1'b0;
            pend_full    <= 1'b0;
            pend_rq_mac  <= '0;
            pend_rq_ip   <= '0;
            pend_loc_mac <= '0;
            pend_loc_ip  <= '0;
            act_rq_mac   <= '0;
            act_rq_ip    <= '0;
            act_loc_mac  <= '0;
            act_loc_ip   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            drop_q  <= rq_valid && pend_full && !load;
            if (load) begin
                act_rq_mac  <= src_rq_mac;
                act_rq_ip   <= src_rq_ip;
                act_loc_mac <= src_loc_mac;
                act_loc_ip  <= src_loc_ip;
            end
            if (rq_valid && (pend_full || !load)) begin
                pend_full    <= 1'b1;
                pend_rq_mac  <= rq_mac_s_addr;
                pend_rq_ip   <= rq_ip_s_addr;
                pend_loc_mac <= local_mac_addr;
                pend_loc_ip  <= local_ip_addr;
            end else if (load) begin
                pend_full <= 1'b0;
            end
        end
    end

    // Bytes past index 41 shift in as zeros, which is the pad.
    assign frame = {
        act_rq_mac, act_loc_mac,
        16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002,
        act_loc_mac, act_loc_ip,
        act_rq_mac, act_rq_ip
    };
    assign frame_sh = frame << {cnt_q, 3'b000};
    assign m_tdata  = m_tvalid ? frame_sh[335:328] : 8'h00;

endmodule

// File: tb/tb_arp_reply_tx.sv
// Directed bench for arp_reply_tx: three instances cover padded,
// inter-frame-gap and unpadded configurations on shared stimulus.
module tb_arp_reply_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] rq_mac = 48'h001122334455;
    logic [31:0] rq_ip = 32'hC0A80102;
    logic        rq_valid = 1'b0;
    logic [47:0] lmac = 48'h020000000001;
    logic [31:0] lip = 32'hC0A8010A;
    logic        tready = 1'b1;

    logic [7:0]  td [3];
    logic        tv [3];
    logic        tl [3];
    logic        bsy [3];
    logic        drp [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];
    int         c0 [$];
    int         drop_cnt [3] = '{0, 0, 0};
    int         stall_err [3] = '{0, 0, 0};
    logic       prev_stall [3] = '{1'b0, 1'b0, 1'b0};
    logic [8:0] prev_b [3] = '{9'h0, 9'h0, 9'h0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        arp_reply_tx #(
            .PAD_EN((g == 2) ? 0 : 1),
            .IFG_CYCLES((g == 1) ? 12 : 0)
        ) dut (
            .mac_gmii_tx_clk(clk),
            .mac_gmii_tx_rst(rst),
            .rq_mac_s_addr(rq_mac),
            .rq_ip_s_addr(rq_ip),
            .rq_valid(rq_valid),
            .local_mac_addr(lmac),
            .local_ip_addr(lip),
            .m_tdata(td[g]),
            .m_tvalid(tv[g]),
            .m_tready(tready),
            .m_tlast(tl[g]),
            .busy(bsy[g]),
            .rq_drop(drp[g])
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (tv[0] && tready) begin
                q0.push_back({tl[0], td[0]});
                c0.push_back(cyc);
            end
            if (tv[1] && tready) q1.push_back({tl[1], td[1]});
            if (tv[2] && tready) q2.push_back({tl[2], td[2]});
        end
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                prev_stall[d] <= 1'b0;
            end else begin
                if (prev_stall[d] && (!tv[d] || {tl[d], td[d]} != prev_b[d]))
                    stall_err[d] <= stall_err[d] + 1;
                if (drp[d]) drop_cnt[d] <= drop_cnt[d] + 1;
                prev_stall[d] <= tv[d] && !tready;
                prev_b[d] <= {tl[d], td[d]};
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int i, input logic [47:0] rm,
                                            input logic [31:0] ri,
                                            input logic [47:0] lm,
                                            input logic [31:0] li);
        logic [79:0] hdr;
        hdr = 80'h0806_0001_0800_0604_0002;
        if (i < 6) return rm[47-8*i -: 8];
        else if (i < 12) return lm[47-8*(i-6) -: 8];
        else if (i < 22) return hdr[79-8*(i-12) -: 8];
        else if (i < 28) return lm[47-8*(i-22) -: 8];
        else if (i < 32) return li[31-8*(i-28) -: 8];
        else if (i < 38) return rm[47-8*(i-32) -: 8];
        else if (i < 42) return ri[31-8*(i-38) -: 8];
        return 8'h00;
    endfunction

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [31:0] ip);
        rq_ip = ip;
        rq_valid = 1'b1;
        tick();
        rq_valid = 1'b0;
    endtask

    task automatic wait_q(input int d, input int n);
        for (int i = 0; i < 400; i++) begin
            if (qsize(d) >= n) break;
            tick();
        end
    endtask

    task automatic test_reset();
        int nb;
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({tv[d], tl[d], bsy[d], drp[d], td[d]} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got v=%b l=%b b=%b d=%b data=%h want all 0",
                         d, tv[d], tl[d], bsy[d], drp[d], td[d]);
            end
        end
        rst = 1'b0;
        tick();
        request(32'hC0A80102);
        wait_q(0, q0.size() + 5);
        request(32'hC0A80103);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nb = q0.size();
        repeat (80) tick();
        checks++;
        if (q0.size() != nb) begin
            errors++;
            $display("FAIL reset_pending_cleared got %0d bytes after reset want 0", q0.size() - nb);
        end
        checks++;
        if (bsy[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_idle got %b want 0", bsy[0]);
        end
    endtask

    task automatic test_single();
        int b, cr, n;
        logic [8:0] e;
        b = q0.size();
        tready = 1'b1;
        request(32'hC0A80102);
        cr = cyc;
        wait_q(0, b + 60);
        repeat (5) tick();
        checks++;
        if (q0.size() != b + 60) begin
            errors++;
            $display("FAIL single_len got %0d want 60", q0.size() - b);
        end
        n = (q0.size() - b < 60) ? q0.size() - b : 60;
        for (int i = 0; i < n; i++) begin
            e = {(i == 59), exp_byte(i, rq_mac, 32'hC0A80102, lmac, lip)};
            checks++;
            if (q0[b+i] !== e) begin
                errors++;
                $display("FAIL single_byte[%0d] got %h want %h", i, q0[b+i], e);
            end
            checks++;
            if (c0[b+i] != cr + i) begin
                errors++;
                $display("FAIL single_cycle[%0d] got %0d want %0d", i, c0[b+i], cr + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int b, s, n;
        logic [8:0] e;
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        b = q0.size();
        s = stall_err[0];
        tready = 1'b1;
        request(32'hC0A80102);
        for (int k = 0; k < 400; k++) begin
            if (q0.size() >= b + 60) break;
            tready = pat[k % 4];
            tick();
        end
        tready = 1'b1;
        repeat (5) tick();
        checks++;
        if (q0.size() != b + 60) begin
            errors++;
            $display("FAIL bp_len got %0d want 60", q0.size() - b);
        end
        checks++;
        if (stall_err[0] != s) begin
            errors++;
            $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err[0] - s);
        end
        n = (q0.size() - b < 60) ? q0.size() - b : 60;
        for (int i = 0; i < n; i++) begin
            e = {(i == 59), exp_byte(i, rq_mac, 32'hC0A80102, lmac, lip)};
            checks++;
            if (q0[b+i] !== e) begin
                errors++;
                $display("FAIL bp_byte[%0d] got %h want %h", i, q0[b+i], e);
            end
        end
    endtask

    task automatic test_back_to_back();
        int b, d0, n;
        logic [31:0] old_lip, ip;
        logic [8:0] e;
        b = q0.size();
        d0 = drop_cnt[0];
        old_lip = lip;
        request(32'hC0A80102);
        wait_q(0, b + 10);
        request(32'hC0A80103);
        lip = 32'hC0A80199;
        wait_q(0, b + 120);
        repeat (10) tick();
        lip = old_lip;
        checks++;
        if (q0.size() != b + 120) begin
            errors++;
            $display("FAIL b2b_len got %0d want 120", q0.size() - b);
        end
        checks++;
        if (drop_cnt[0] != d0) begin
            errors++;
            $display("FAIL b2b_no_drop got %0d drops want 0", drop_cnt[0] - d0);
        end
        n = (q0.size() - b < 120) ? q0.size() - b : 120;
        if (n == 120) begin
            checks++;
            if (c0[b+60] != c0[b+59] + 1) begin
                errors++;
                $display("FAIL b2b_gap got cycle %0d want %0d", c0[b+60], c0[b+59] + 1);
            end
        end
        for (int i = 0; i < n; i++) begin
            ip = (i < 60) ? 32'hC0A80102 : 32'hC0A80103;
            e = {((i % 60) == 59), exp_byte(i % 60, rq_mac, ip, lmac, old_lip)};
            checks++;
            if (q0[b+i] !== e) begin
                errors++;
                $display("FAIL b2b_byte[%0d] got %h want %h", i, q0[b+i], e);
            end
        end
    endtask

    task automatic test_overwrite();
        int b, d0, n;
        logic [31:0] ip;
        logic [8:0] e;
        b = q0.size();
        d0 = drop_cnt[0];
        request(32'hC0A80102);
        wait_q(0, b + 10);
        request(32'hC0A80103);
        wait_q(0, b + 20);
        request(32'hC0A80104);
        wait_q(0, b + 120);
        repeat (100) tick();
        checks++;
        if (q0.size() != b + 120) begin
            errors++;
            $display("FAIL ovw_len got %0d want 120", q0.size() - b);
        end
        checks++;
        if (drop_cnt[0] != d0 + 1) begin
            errors++;
            $display("FAIL ovw_drop got %0d drop cycles want 1", drop_cnt[0] - d0);
        end
        n = (q0.size() - b < 120) ? q0.size() - b : 120;
        for (int i = 0; i < n; i++) begin
            ip = (i < 60) ? 32'hC0A80102 : 32'hC0A80104;
            e = {((i % 60) == 59), exp_byte(i % 60, rq_mac, ip, lmac, lip)};
            checks++;
            if (q0[b+i] !== e) begin
                errors++;
                $display("FAIL ovw_byte[%0d] got %h want %h", i, q0[b+i], e);
            end
        end
    endtask

    task automatic test_ifg();
        int b, gaps, berr;
        logic [8:0] e;
        b = q1.size();
        gaps = 0;
        berr = 0;
        request(32'hC0A80102);
        wait_q(1, b + 10);
        request(32'hC0A80103);
        wait_q(1, b + 60);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tv[1]) break;
            gaps++;
            if (bsy[1] !== 1'b1) berr++;
        end
        #1;
        checks++;
        if (gaps != 12) begin
            errors++;
            $display("FAIL ifg_idle_cycles got %0d want 12", gaps);
        end
        checks++;
        if (berr != 0) begin
            errors++;
            $display("FAIL ifg_busy got %0d cycles with busy=0 want 0", berr);
        end
        wait_q(1, b + 120);
        repeat (5) tick();
        checks++;
        if (q1.size() != b + 120) begin
            errors++;
            $display("FAIL ifg_len got %0d want 120", q1.size() - b);
        end
        if (q1.size() >= b + 120) begin
            for (int i = 98; i < 120; i++) begin
                e = {(i == 119), exp_byte(i - 60, rq_mac, 32'hC0A80103, lmac, lip)};
                checks++;
                if (q1[b+i] !== e) begin
                    errors++;
                    $display("FAIL ifg_byte[%0d] got %h want %h", i, q1[b+i], e);
                end
            end
        end
    endtask

    task automatic test_pad_reset();
        int b, b2, b3, n;
        logic [8:0] e;
        b = q2.size();
        request(32'hC0A80102);
        wait_q(2, b + 42);
        repeat (5) tick();
        checks++;
        if (q2.size() != b + 42) begin
            errors++;
            $display("FAIL nopad_len got %0d want 42", q2.size() - b);
        end
        n = (q2.size() - b < 42) ? q2.size() - b : 42;
        for (int i = 0; i < n; i++) begin
            e = {(i == 41), exp_byte(i, rq_mac, 32'hC0A80102, lmac, lip)};
            checks++;
            if (q2[b+i] !== e) begin
                errors++;
                $display("FAIL nopad_byte[%0d] got %h want %h", i, q2[b+i], e);
            end
        end
        b2 = q2.size();
        request(32'hC0A80105);
        wait_q(2, b2 + 20);
        rst = 1'b1;
        tick();
        checks++;
        if (tv[2] !== 1'b0 || bsy[2] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_drop got v=%b b=%b want 0 0", tv[2], bsy[2]);
        end
        rst = 1'b0;
        repeat (20) tick();
        checks++;
        if (q2.size() != b2 + 20) begin
            errors++;
            $display("FAIL midreset_trunc got %0d bytes want 20", q2.size() - b2);
        end
        b3 = q2.size();
        request(32'hC0A80106);
        wait_q(2, b3 + 42);
        repeat (5) tick();
        checks++;
        if (q2.size() != b3 + 42) begin
            errors++;
            $display("FAIL postreset_len got %0d want 42", q2.size() - b3);
        end
        n = (q2.size() - b3 < 42) ? q2.size() - b3 : 42;
        for (int i = 0; i < n; i++) begin
            e = {(i == 41), exp_byte(i, rq_mac, 32'hC0A80106, lmac, lip)};
            checks++;
            if (q2[b3+i] !== e) begin
                errors++;
                $display("FAIL postreset_byte[%0d] got %h want %h", i, q2[b3+i], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overwrite();
        test_ifg();
        test_pad_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
